// File: rtl/scan_seq_if.sv
// Handshake/control bundle between a scan_seq controller and whatever drives it.
// The master side sets scan configuration; the slave (scan_seq) returns decoder select/enable.
interface scan_seq_if #(
  parameter int CNT_W = 16
);
  logic             run;
  logic [1:0]       mode;
  logic             start;
  logic [CNT_W-1:0] div;
  logic [2:0]       last;
  logic [3:0]       blank;
  logic [2:0]       sel;
  logic             en;
  logic             step;
  logic             done;
  logic             busy;

  modport master (
    output run, mode, start, div, last, blank,
    input  sel, en, step, done, busy
  );

  modport slave (
    input  run, mode, start, div, last, blank,
    output sel, en, step, done, busy
  );
endinterface

// File: rtl/scan_seq.sv
// Scan sequencer driving a 3-to-8 decoder: prescaled dwell per index, leading blanking
// window, and up / down / ping-pong / single-sweep index ordering.
//
// state   | meaning
// S_IDLE  | outputs parked, waiting for run (modes 00/01/10) or start (mode 11)
// S_RUN   | continuous scanning while run=1 and mode!=11
// S_SWEEP | one pass over 0..last, then done pulse and back to idle
module scan_seq #(
  parameter int CNT_W = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  scan_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_SWEEP = 2'd2
  } state_t;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dir;
  logic [2:0]       r_sel;
  logic             r_en;
  logic             r_step;
  logic             r_done;
  logic             r_busy;

  logic             w_boundary;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [CNT_W-1:0] w_blank_ext;
  logic             w_en_inc;
  logic             w_en_zero;
  logic [2:0]       w_sel_nxt;
  logic             w_dir_nxt;

  // >= rather than == so a div lowered below cnt ends the dwell on the next cycle
  assign w_boundary  = (r_cnt >= bus.div);
  assign w_cnt_inc   = r_cnt + CNT_W'(1);
  assign w_blank_ext = CNT_W'(bus.blank);
  assign w_en_inc    = (w_cnt_inc >= w_blank_ext);
  assign w_en_zero   = (bus.blank == 4'd0);

  always_comb begin
    w_sel_nxt = r_sel;
    w_dir_nxt = r_dir;
    case (bus.mode)
      2'b01: begin
        if ((r_sel > bus.last) || (r_sel == 3'd0)) w_sel_nxt = bus.last;
        else                                       w_sel_nxt = r_sel - 3'd1;
      end
      2'b10: begin
        if (r_sel > bus.last) begin
          w_sel_nxt = 3'd0;
          w_dir_nxt = DIR_UP;
        end else if (bus.last == 3'd0) begin
          w_sel_nxt = 3'd0;
        end else if (r_dir == DIR_UP) begin
          if (r_sel == bus.last) begin
            w_sel_nxt = r_sel - 3'd1;
            w_dir_nxt = DIR_DN;
          end else begin
            w_sel_nxt = r_sel + 3'd1;
          end
        end else begin
          if (r_sel == 3'd0) begin
            w_sel_nxt = 3'd1;
            w_dir_nxt = DIR_UP;
          end else begin
            w_sel_nxt = r_sel - 3'd1;
          end
        end
      end
      default: begin
        if (r_sel >= bus.last) begin
          w_sel_nxt = 3'd0;
          if (r_sel > bus.last) w_dir_nxt = DIR_UP;
        end else begin
          w_sel_nxt = r_sel + 3'd1;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_dir   <= DIR_UP;
      r_sel   <= 3'd0;
      r_en    <= 1'b0;
      r_step  <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_step <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          r_en  <= 1'b0;
          if (bus.run && (bus.mode != 2'b11)) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
            r_en    <= w_en_zero;
            if (bus.mode == 2'b01) begin
              r_sel <= bus.last;
            end else begin
              r_sel <= 3'd0;
              r_dir <= DIR_UP;
            end
          end else if (bus.start && (bus.mode == 2'b11)) begin
            r_state <= S_SWEEP;
            r_busy  <= 1'b1;
            r_en    <= w_en_zero;
            r_sel   <= 3'd0;
          end
        end
        S_RUN: begin
          if (!bus.run || (bus.mode == 2'b11)) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_en    <= 1'b0;
            r_cnt   <= '0;
          end else if (w_boundary) begin
            r_cnt  <= '0;
            r_sel  <= w_sel_nxt;
            r_dir  <= w_dir_nxt;
            r_step <= 1'b1;
            r_en   <= w_en_zero;
          end else begin
            r_cnt <= w_cnt_inc;
            r_en  <= w_en_inc;
          end
        end
        S_SWEEP: begin
          if (w_boundary) begin
            r_cnt <= '0;
            if (r_sel >= bus.last) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_en    <= 1'b0;
              r_sel   <= 3'd0;
            end else begin
              r_sel  <= r_sel + 3'd1;
              r_step <= 1'b1;
              r_en   <= w_en_zero;
            end
          end else begin
            r_cnt <= w_cnt_inc;
            r_en  <= w_en_inc;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.sel  = r_sel;
  assign bus.en   = r_en;
  assign bus.step = r_step;
  assign bus.done = r_done;
  assign bus.busy = r_busy;

endmodule

// File: doc/scan_seq.md
# scan_seq

Programmable scan sequencer that generates the 3-bit select index and enable driving the 3-to-8 decoder stage (`in`/`en` of the decoder), e.g. for multiplexed 8-digit display or 8-row LED scanning. A prescaler sets the dwell time per index. A blanking window at the start of each dwell suppresses ghosting. Four scan modes are supported: up, down, ping-pong and triggered single sweep.

## Interface
- `CNT_W`, 16: width of the dwell prescaler and `div` input.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `run`  in  1  level; enables continuous scanning in modes 00/01/10.
- `mode`  in  2  00 up, 01 down, 10 ping-pong, 11 single sweep.
- `start`  in  1  one-cycle pulse; launches a sweep in mode 11.
- `div`  in  CNT_W  dwell per index = `div`+1 cycles.
- `last`  in  3  highest index used (scan range 0..`last`).
- `blank`  in  4  cycles at start of each dwell with `en` forced 0.
- `sel`  out  3  current index, registered; feeds decoder `in`.
- `en`  out  1  registered; feeds decoder `en`.
- `step`  out  1  one-cycle pulse in the first cycle `sel` shows a new index.
- `done`  out  1  one-cycle pulse when a single sweep finishes.
- `busy`  out  1  high while not IDLE.

## Operation
- States: IDLE, RUN (modes 00/01/10), SWEEP (mode 11). Internal: prescaler `cnt` (CNT_W bits) and ping-pong direction `dir`.
- Reset values: state IDLE, `cnt`=0, `dir`=up, `sel`=0, `en`=0, `step`=0, `done`=0, `busy`=0.
- IDLE→RUN: `run`=1 and `mode`≠11.
  - `cnt`←0.
  - `sel`←`last` for mode 01; otherwise `sel`←0 with `dir`=up.
- IDLE→SWEEP: `start`=1 and `mode`=11. Sets `cnt`←0 and `sel`←0. `run` is ignored in mode 11.
- RUN→IDLE: `run`=0 or `mode`=11.
  - Takes effect at the next edge: `en`←0, `cnt`←0.
  - `sel` holds its value.
  - No partial-dwell completion.
- Dwell: `cnt` counts 0..`div`. At `cnt`=`div` a step boundary occurs: `cnt`←0, `sel` advances and `step` pulses.
- `en`=1 only in RUN/SWEEP when the next-cycle `cnt` ≥ `blank`.
  - `blank`=0 gives continuous `en`.
  - `blank`>`div` gives `en` permanently 0 while scanning; `sel` and `step` still advance.
- Advance rules at a boundary:
  - Up: `sel`=`last` wraps to 0, else `sel`+1.
  - Down: `sel`=0 wraps to `last`, else `sel`−1.
  - Ping-pong: `dir` reverses at 0 and at `last` with no repeated endpoint (`last`=2 gives 0,1,2,1,0,1…). `last`=0 holds `sel`=0; `step` still pulses.
- `mode` changes between 00/01/10 in RUN apply at the next boundary. Switching into ping-pong keeps `dir` unchanged.
- Out-of-range: if `sel`>`last` at a boundary (`last` reduced mid-scan), the next `sel` is 0 for up/ping-pong (with `dir`=up) and `last` for down.
- `div`, `last` and `blank` are sampled live every cycle. A `div` lowered below the current `cnt` ends the dwell at the next cycle, treated as a boundary.
- SWEEP: visits 0..`last` once, each for `div`+1 cycles. At the boundary after `sel`=`last`:
  - state→IDLE, `done`=1 for one cycle.
  - `en`=0, `sel`←0, no `step` pulse.
- SWEEP is uninterruptible except by `rst`. `start` is ignored while `busy`=1; `mode` changes during SWEEP are ignored.
- `rst` mid-operation returns all registers to their reset values immediately (asynchronous); no `done` pulse.

## Timing
- All outputs are registered; no combinational input-to-output path.
- Start latency: `run` or `start` sampled high at edge E → `busy`=1 and initial `sel` valid after E. `en`=1 after E if `blank`=0, otherwise after edge E+`blank`.
- `step` is never asserted on the IDLE→RUN/SWEEP entry cycle.
- Step period is exactly `div`+1 cycles. `en` is high for (`div`+1−`blank`) cycles per dwell when `blank`≤`div`.
- Single-sweep length: (`last`+1)·(`div`+1) cycles from entry to the `done` cycle. `busy` falls in the same cycle `done` rises.
- `run` deasserted at edge E → `en`=0 and `busy`=0 after E.

## Test plan
- Up scan: `div`=3, `blank`=0, `last`=7, mode 00, `run`=1 → `sel` 0..7,0 in 4-cycle dwells; `en` constantly 1; `step` every 4 cycles.
- Blanking: `div`=4, `blank`=2, mode 00 → each dwell shows `en` 0,0,1,1,1. With `blank`=9 instead: `en` never 1 while `sel` still advances.
- Ping-pong: `last`=3, `div`=0 → `sel` 0,1,2,3,2,1,0,1 on consecutive cycles. With `last`=0: `sel` stays 0 and `step` pulses every cycle.
- Single sweep: mode 11, `last`=2, `div`=1, `start` pulse →
  - `sel` 0,0,1,1,2,2, then `done`=1 with `busy`=0 at cycle 6.
  - A second `start` during the sweep is ignored.
- Boundary edits: in up mode at `sel`=6, change `last` to 3 → next `sel`=0. In down mode, entry gives `sel`=`last`.
- Reset/abort:
  - `rst` pulse mid-sweep → all outputs 0 asynchronously; no `done`.
  - `run` dropped mid-dwell → `en`=0 next cycle.
  - Re-assert `run` → restart at the initial index with a full dwell.
